// File: rtl/pulse_spacer_pkg.sv
// Shared types and constants for the pulse_spacer block.
package pulse_spacer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FIRE = 2'b01,
    GAP  = 2'b10
  } state_e;

  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/pulse_spacer_if.sv
// Request/status bundle between a pulse_spacer and its user.
// drop_cnt exists only when PULSE_SPACER_DROPCNT_EN is defined.
interface pulse_spacer_if #(
  parameter int CNT_W = 4
) ();
  logic             event_in;
  logic             flush;
  logic             clr_ovf;
  logic             pulse_clksrc;
  logic [CNT_W-1:0] pending_cnt;
  logic             busy;
  logic             ovf_flag;
`ifdef PULSE_SPACER_DROPCNT_EN
  logic [pulse_spacer_pkg::DROP_CNT_W-1:0] drop_cnt;

  modport master (
    output event_in, flush, clr_ovf,
    input  pulse_clksrc, pending_cnt, busy, ovf_flag, drop_cnt
  );
  modport slave (
    input  event_in, flush, clr_ovf,
    output pulse_clksrc, pending_cnt, busy, ovf_flag, drop_cnt
  );
`else
  modport master (
    output event_in, flush, clr_ovf,
    input  pulse_clksrc, pending_cnt, busy, ovf_flag
  );
  modport slave (
    input  event_in, flush, clr_ovf,
    output pulse_clksrc, pending_cnt, busy, ovf_flag
  );
`endif
endinterface

// File: rtl/pulse_spacer_sat_updown_cnt.sv
// Saturating up/down counter; sat strobes when an increment is lost at full scale.
module sat_updown_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             sat
);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    sat   = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec) begin
      if (cnt_q == MAX) sat = 1'b1;
      else              cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: state uses non-blocking assignments under an async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pulse_spacer.sv
// Spaces bursty requests into pulses at least MIN_GAP clksrc cycles apart, queuing extras.
// Optional drop counter enabled by PULSE_SPACER_DROPCNT_EN.
module pulse_spacer
  import pulse_spacer_pkg::*;
#(
  parameter int MIN_GAP = 6,
  parameter int CNT_W   = 4
) (
  input  logic           clksrc,
  input  logic           rstb_clksrc,
  pulse_spacer_if.slave  bus
);
  localparam int               GAP_W    = $clog2(MIN_GAP);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 2);

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             pulse_q, pulse_d;
  logic             ovf_q, ovf_d;
  logic             req, enter_fire, lost, pend_nz;
  logic [CNT_W-1:0] pend_cnt;

  assign req     = bus.event_in & ~bus.flush;
  assign pend_nz = (pend_cnt != '0);

  // A held flush blocks every new FIRE, so a flushed queue never leaks a pulse.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: if (!bus.flush && (bus.event_in || pend_nz)) state_d = FIRE;
      FIRE: begin
        state_d = GAP;
        gap_d   = GAP_LOAD;
      end
      GAP: begin
        if (gap_q != '0)               gap_d   = gap_q - 1'b1;
        else if (pend_nz && !bus.flush) state_d = FIRE;
        else                            state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_fire = (state_d == FIRE) && (state_q != FIRE);
  assign pulse_d    = (state_d == FIRE);
  assign ovf_d      = lost | (ovf_q & ~bus.clr_ovf);

  always_ff @(posedge clksrc or negedge rstb_clksrc) begin
    if (!rstb_clksrc) begin
      state_q <= IDLE;
      gap_q   <= '0;
      pulse_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
      ovf_q   <= ovf_d;
    end
  end

  // A request that fires straight from IDLE is both counted and consumed, netting zero.
  sat_updown_cnt #(.WIDTH(CNT_W)) u_pend (
    .clk   (clksrc),
    .rst_n (rstb_clksrc),
    .inc   (req),
    .dec   (enter_fire),
    .clr   (bus.flush),
    .cnt   (pend_cnt),
    .sat   (lost)
  );

`ifdef PULSE_SPACER_DROPCNT_EN
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (bus.clr_ovf)                        drop_d = {{(DROP_CNT_W-1){1'b0}}, lost};
    else if (lost && drop_q != '1)          drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clksrc or negedge rstb_clksrc) begin
    if (!rstb_clksrc) drop_q <= '0;
    else              drop_q <= drop_d;
  end

  assign bus.drop_cnt = drop_q;
`endif

  assign bus.pulse_clksrc = pulse_q;
  assign bus.pending_cnt  = pend_cnt;
  assign bus.ovf_flag     = ovf_q;
  assign bus.busy         = (state_q != IDLE) || pend_nz;

endmodule

// File: tb/tb_pulse_spacer.sv
// Scoreboard bench for pulse_spacer: stimulus queues expected pulse cycles, a monitor checks them.
module tb_pulse_spacer;

  logic clksrc      = 1'b0;
  logic rstb_clksrc = 1'b0;
  always #5 clksrc = ~clksrc;

  pulse_spacer_if #(.CNT_W(4)) bus ();

  pulse_spacer #(.MIN_GAP(6), .CNT_W(4)) dut (
    .clksrc      (clksrc),
    .rstb_clksrc (rstb_clksrc),
    .bus         (bus)
  );

  int cyc = 0;
  always @(posedge clksrc) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every observed pulse must match the oldest expected pulse cycle.
  int exp_cyc;
  always @(negedge clksrc) begin
    if (bus.pulse_clksrc === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pulse_unexpected: got pulse at cycle %0d, expected none", cyc);
      end else begin
        exp_cyc = sb.pop_front();
        check("pulse_cycle", cyc, exp_cyc);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clksrc);
      #1;
    end
  endtask

  task automatic drive_events(input int n, output int pmax);
    pmax = 0;
    bus.event_in = 1'b1;
    repeat (n) begin
      tick();
      if (int'(bus.pending_cnt) > pmax) pmax = int'(bus.pending_cnt);
    end
    bus.event_in = 1'b0;
  endtask

  int c0, pmax, busy_cycles;

  initial begin
    bus.event_in = 1'b0;
    bus.flush    = 1'b0;
    bus.clr_ovf  = 1'b0;
    tick(2);
    check("rst_pulse",   bus.pulse_clksrc, 0);
    check("rst_pending", bus.pending_cnt,  0);
    check("rst_busy",    bus.busy,         0);
    check("rst_ovf",     bus.ovf_flag,     0);
`ifdef PULSE_SPACER_DROPCNT_EN
    check("rst_drop",    bus.drop_cnt,     0);
`endif
    rstb_clksrc = 1'b1;
    tick(2);

    // Single request: one pulse next cycle, busy for 6 cycles.
    c0 = cyc;
    sb.push_back(c0 + 1);
    bus.event_in = 1'b1;
    tick();
    bus.event_in = 1'b0;
    busy_cycles = 0;
    pmax = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.busy) busy_cycles++;
      if (int'(bus.pending_cnt) > pmax) pmax = int'(bus.pending_cnt);
      tick();
    end
    check("single_busy_cycles", busy_cycles, 6);
    check("single_pending_max", pmax, 0);

    // Burst of 4: pulses 6 apart, pending peaks at 3.
    c0 = cyc;
    sb.push_back(c0 + 1);
    sb.push_back(c0 + 7);
    sb.push_back(c0 + 13);
    sb.push_back(c0 + 19);
    drive_events(4, pmax);
    check("burst_pending_peak", pmax, 3);
    tick(22);
    check("burst_pending_end", bus.pending_cnt, 0);
    check("burst_busy_end",    bus.busy,        0);

    // Saturation: 20 requests, 4 issued in-burst, 15 queued, 1 lost.
    c0 = cyc;
    for (int k = 0; k < 19; k++) sb.push_back(c0 + 1 + 6 * k);
    drive_events(20, pmax);
    check("sat_pending", bus.pending_cnt, 15);
    check("sat_ovf",     bus.ovf_flag,    1);
`ifdef PULSE_SPACER_DROPCNT_EN
    check("sat_drop",    bus.drop_cnt,    1);
`endif
    // Overflow coinciding with clr_ovf: overflow wins.
    bus.event_in = 1'b1;
    bus.clr_ovf  = 1'b1;
    tick();
    bus.event_in = 1'b0;
    check("sat_clr_race_ovf",     bus.ovf_flag,    1);
    check("sat_clr_race_pending", bus.pending_cnt, 15);
`ifdef PULSE_SPACER_DROPCNT_EN
    check("sat_clr_race_drop",    bus.drop_cnt,    1);
`endif
    tick();
    bus.clr_ovf = 1'b0;
    check("sat_clr_ovf", bus.ovf_flag, 0);
`ifdef PULSE_SPACER_DROPCNT_EN
    check("sat_clr_drop", bus.drop_cnt, 0);
`endif
    tick(96);
    check("sat_drain_pending", bus.pending_cnt, 0);
    check("sat_drain_busy",    bus.busy,        0);

    // Flush during GAP with 5 queued; events under flush are discarded.
    c0 = cyc;
    sb.push_back(c0 + 1);
    drive_events(6, pmax);
    check("flush_pending_before", bus.pending_cnt, 5);
    bus.flush    = 1'b1;
    bus.event_in = 1'b1;
    tick(2);
    bus.flush    = 1'b0;
    bus.event_in = 1'b0;
    check("flush_pending_after", bus.pending_cnt, 0);
    tick(15);
    check("flush_busy_end", bus.busy, 0);

    // Flush does not abort a gap in progress.
    c0 = cyc;
    sb.push_back(c0 + 1);
    bus.event_in = 1'b1;
    tick();
    bus.event_in = 1'b0;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick(3);
    check("flush_gap_kept_busy", bus.busy, 1);
    tick();
    check("flush_gap_done_busy", bus.busy, 0);

    // Async reset mid-gap with 7 pending.
    c0 = cyc;
    sb.push_back(c0 + 1);
    sb.push_back(c0 + 7);
    drive_events(9, pmax);
    check("rst_mid_pending_before", bus.pending_cnt, 7);
    check("rst_mid_busy_before",    bus.busy,        1);
    #2 rstb_clksrc = 1'b0;
    #1;
    check("rst_mid_pending", bus.pending_cnt,  0);
    check("rst_mid_busy",    bus.busy,         0);
    check("rst_mid_pulse",   bus.pulse_clksrc, 0);
    check("rst_mid_ovf",     bus.ovf_flag,     0);
    tick(2);
    rstb_clksrc = 1'b1;
    tick();
    c0 = cyc;
    sb.push_back(c0 + 1);
    bus.event_in = 1'b1;
    tick();
    bus.event_in = 1'b0;
    tick(8);
    check("post_rst_pending", bus.pending_cnt, 0);
    check("post_rst_busy",    bus.busy,        0);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_spacer.md
Name: pulse_spacer

Overview:
- Source-domain stage that feeds pulse_sync: it converts bursty single-cycle event requests into output pulses spaced at least MIN_GAP clksrc cycles apart.
- The spacing ensures pulse_sync never receives pulses faster than it can carry them across domains.
- Requests that arrive while a pulse is being spaced are queued in a saturating pending counter.
- An overflow flag records any requests lost once the counter saturates.

Parameters:
- MIN_GAP, 6, clksrc cycles between successive rising edges of pulse_clksrc; legal range 2..255. Default covers the 10 ns source / 15 ns destination clock pairing.
- CNT_W, 4, width of the pending counter; the counter saturates at 2^CNT_W-1.

Ports:
- clksrc  input  1  source-domain clock; the block has one clock.
- rstb_clksrc  input  1  reset, asynchronous assert, active-low.
- event_in  input  1  request, one per high cycle; sampled every clksrc rising edge.
- flush  input  1  synchronous clear of the pending count.
- clr_ovf  input  1  synchronous clear of ovf_flag.
- pulse_clksrc  output  1  spaced single-cycle pulse; connects to pulse_sync pulse_clksrc.
- pending_cnt  output  CNT_W  requests queued but not yet issued.
- busy  output  1  high when the FSM is not in IDLE or pending_cnt != 0.
- ovf_flag  output  1  sticky; a request was lost at saturation.

Behaviour:
- Reset (rstb_clksrc=0): state=IDLE, gap counter=0, pending_cnt=0, pulse_clksrc=0, ovf_flag=0, busy=0. Reset is asynchronous and takes effect immediately, including mid-gap. The state value is fully registered.
- pulse_clksrc is a registered output, high exactly while state==FIRE. Pulse width is always 1 cycle.
- FSM state IDLE:
  - Go to FIRE if (event_in & ~flush) or pending_cnt != 0.
  - Otherwise stay in IDLE.
- FSM state FIRE:
  - Always go to GAP and load the gap counter with MIN_GAP-2.
- FSM state GAP:
  - If gap counter != 0, decrement it and stay in GAP.
  - If gap counter == 0 and pending_cnt != 0, go to FIRE (the next pulse leads the previous one by exactly MIN_GAP cycles).
  - If gap counter == 0 and pending_cnt == 0, go to IDLE.
- Latency:
  - event_in sampled at edge t with the FSM in IDLE and pending 0 gives pulse_clksrc high in the cycle after edge t. Latency is 1 cycle and the count is unchanged.
  - Queued requests issue back to back, MIN_GAP apart.
- Pending counter:
  - inc = event_in & ~flush.
  - dec = transition into FIRE taken on this edge.
  - Next count = cnt + inc - dec. inc and dec together leave the count unchanged.
- Saturation: with inc=1, dec=0 and cnt = 2^CNT_W-1, the count holds and ovf_flag is set.
- flush:
  - pending_cnt becomes 0 and event_in is discarded in the same cycle; flush wins.
  - flush does not abort a FIRE or GAP already in progress.
  - With flush held, no new FIRE is entered from IDLE or GAP.
- ovf_flag:
  - clr_ovf clears it.
  - If a new overflow occurs in the same cycle as clr_ovf, the overflow wins and the flag stays 1.
- busy is combinational from registered state only.
- Arithmetic is unsigned; the gap counter width is clog2(MIN_GAP).

Optional Feature:
- PULSE_SPACER_DROPCNT_EN defined:
  - Adds output drop_cnt [7:0], which counts every lost request (each saturation event).
  - drop_cnt saturates at 255, resets to 0, and is cleared by clr_ovf.
  - Overflow and clear in the same cycle leaves drop_cnt = 1.
- Undefined: the drop_cnt port and its logic are absent; ovf_flag behaviour is identical in both builds.

Decomposition:
- pulse_spacer_pkg holds:
  - the state typedef: IDLE=2'b00, FIRE=2'b01, GAP=2'b10;
  - the drop counter width constant (8).
- One sub-module is natural: sat_updown_cnt (width parameter; inc/dec/clr inputs; sat output), used for pending_cnt.
- The FSM and gap counter live in the top level.

Test Plan:
All scenarios use defaults (MIN_GAP=6, CNT_W=4) unless stated.
- Single request: event_in high 1 cycle in IDLE -> pulse_clksrc high the next cycle for exactly 1 cycle; pending_cnt stays 0; busy high for 6 cycles total, then low.
- Burst: event_in high for 4 consecutive cycles -> 4 pulses at cycles t+1, t+7, t+13, t+19; pending_cnt peaks at 3 and returns to 0.
- Saturation: event_in high for 20 cycles -> pending_cnt sticks at 15; ovf_flag=1; with PULSE_SPACER_DROPCNT_EN, drop_cnt=1 (20 requests, 4 issued during the burst, 15 queued).
- Flush mid-gap: 5 queued, flush asserted during GAP -> the current gap completes; pending_cnt=0; no further pulses; FSM returns to IDLE.
- Reset mid-operation: rstb_clksrc low during GAP with pending_cnt=7 -> all outputs 0 immediately; release followed by one event -> pulse 1 cycle later.
- Integration with pulse_sync (10 ns / 15 ns clocks): a 10-request burst -> exactly 10 pulse_clkdest pulses; none merged or lost.
